// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and defaults for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int DATA_SIZE        = 32;
  localparam int DEF_MEM_LATENCY  = 3;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int CNT_WIDTH        = 4;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_SERVE_IF = 2'd1,
    ARB_SERVE_DM = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signals of the arbiter, bundled with a slave
// modport for the arbiter and a master modport for requesters plus memory.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DATA_SIZE,
  parameter int DATA_WIDTH = DATA_SIZE
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_ready;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic                  dm_ready;
  logic [DATA_WIDTH-1:0] dm_rdata;
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_ready, if_rdata, dm_ready, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_ready, if_rdata, dm_ready, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter_arb_latency_counter.sv
// Access latency counter: loads a start value, counts down to zero and flags zero.
module mem_port_arbiter_arb_latency_counter
  import mem_port_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 dec,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 zero
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  // next count: load wins over decrement, never wraps below zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != {CNT_WIDTH{1'b0}})) begin
      cnt_d = cnt_q - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == {CNT_WIDTH{1'b0}});

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and
// the load/store path; data wins unless fetch has been starved too long.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = DATA_SIZE,
  parameter int DATA_WIDTH   = DATA_SIZE,
  parameter int MEM_LATENCY  = DEF_MEM_LATENCY,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] LAT_LOAD = CNT_WIDTH'(MEM_LATENCY - 1);
  localparam logic [CNT_WIDTH-1:0] STARVE_MAX = CNT_WIDTH'(STARVE_LIMIT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  arb_state_e            state_q, state_d;
  logic                  if_ready_q, if_ready_d;
  logic                  dm_ready_q, dm_ready_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  busy_q, busy_d;
  logic [CNT_WIDTH-1:0]  starve_q, starve_d;
  logic                  cnt_load, cnt_dec, cnt_zero;
  logic [CNT_WIDTH-1:0]  cnt_val;
  logic                  dm_wins;

  mem_port_arbiter_arb_latency_counter u_lat_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (LAT_LOAD),
    .dec      (cnt_dec),
    .cnt      (cnt_val),
    .zero     (cnt_zero)
  );

  assign dm_wins = bus.dm_req && !(bus.if_req && (starve_q == STARVE_MAX));

  // arbitration, access sequencing and registered-output next values
  always_comb begin
    state_d     = state_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    starve_d    = starve_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (dm_wins) begin
          state_d     = ARB_SERVE_DM;
          mem_en_d    = 1'b1;
          mem_we_d    = bus.dm_we;
          mem_addr_d  = bus.dm_addr;
          mem_wdata_d = bus.dm_wdata;
          cnt_load    = 1'b1;
          if (bus.if_req) begin
            starve_d = (starve_q == STARVE_MAX) ? STARVE_MAX : (starve_q + CNT_ONE);
          end else begin
            starve_d = {CNT_WIDTH{1'b0}};
          end
        end else if (bus.if_req) begin
          state_d    = ARB_SERVE_IF;
          mem_en_d   = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = bus.if_addr;
          cnt_load   = 1'b1;
          starve_d   = {CNT_WIDTH{1'b0}};
        end else begin
          starve_d = {CNT_WIDTH{1'b0}};
        end
      end
      ARB_SERVE_IF, ARB_SERVE_DM: begin
        if (cnt_zero) begin
          state_d  = ARB_IDLE;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if (state_q == ARB_SERVE_IF) begin
            if_ready_d = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end else begin
            dm_ready_d = 1'b1;
            // stores leave the last load result untouched
            if (!mem_we_q) begin
              dm_rdata_d = bus.mem_rdata;
            end else begin
              dm_rdata_d = dm_rdata_q;
            end
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_d  = ARB_IDLE;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ARB_IDLE);
  end

  // state and output registers; reset aborts any access in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      if_rdata_q  <= {DATA_WIDTH{1'b0}};
      dm_rdata_q  <= {DATA_WIDTH{1'b0}};
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_WIDTH{1'b0}};
      mem_wdata_q <= {DATA_WIDTH{1'b0}};
      busy_q      <= 1'b0;
      starve_q    <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      starve_q    <= starve_d;
    end
  end

  assign bus.if_ready  = if_ready_q;
  assign bus.dm_ready  = dm_ready_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LATENCY=3, STARVE_LIMIT=4.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  int          en_n, we_n, ifr_n, dmr_n, ifr_at, dmr_at;
  logic [31:0] grants[$];
  logic [31:0] first_wdata;
  logic [31:0] got;
  int          en_cnt;

  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_port_arbiter #(
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (32),
    .MEM_LATENCY  (3),
    .STARVE_LIMIT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h8C22_0004;
    else return a ^ 32'hA5A5_5A5A;
  endfunction

  // memory returns valid data only in the third (last) cycle of an access
  always @(posedge clk or posedge reset) begin
    if (reset) en_cnt <= 0;
    else if (bus.mem_en) en_cnt <= en_cnt + 1;
    else en_cnt <= 0;
  end
  assign bus.mem_rdata = (bus.mem_en && en_cnt == 2) ? mem_model(bus.mem_addr) : 32'h0BAD_0BAD;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // watch ncyc falling edges; requesters drop req on their ready unless hold
  task automatic monitor(input int ncyc, input bit hold);
    logic prev_en;
    prev_en = bus.mem_en;
    en_n = 0; we_n = 0; ifr_n = 0; dmr_n = 0; ifr_at = 0; dmr_at = 0;
    grants.delete();
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      if (bus.mem_en) begin
        en_n++;
        if (bus.mem_we) we_n++;
        if (!prev_en) begin
          grants.push_back(bus.mem_addr);
          first_wdata = bus.mem_wdata;
        end
      end
      prev_en = bus.mem_en;
      if (bus.if_ready) begin
        ifr_n++;
        if (ifr_at == 0) ifr_at = i;
        if (!hold) bus.if_req = 1'b0;
      end
      if (bus.dm_ready) begin
        dmr_n++;
        if (dmr_at == 0) dmr_at = i;
        if (!hold) bus.dm_req = 1'b0;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = 32'h0; bus.dm_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check_val("rst_mem_en",   {31'd0, bus.mem_en},   32'd0);
    check_val("rst_busy",     {31'd0, bus.busy},     32'd0);
    check_val("rst_if_ready", {31'd0, bus.if_ready}, 32'd0);
    check_val("rst_dm_ready", {31'd0, bus.dm_ready}, 32'd0);
    check_val("rst_if_rdata", bus.if_rdata,          32'd0);
    check_val("rst_dm_rdata", bus.dm_rdata,          32'd0);
    check_val("rst_mem_addr", bus.mem_addr,          32'd0);
    reset = 1'b0;
    @(negedge clk);

    // single fetch
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0040;
    monitor(8, 1'b0);
    check_val("fetch_en_cycles", en_n, 32'd3);
    check_val("fetch_addr",      (grants.size() > 0) ? grants[0] : 32'hFFFF_FFFF, 32'h0000_0040);
    check_val("fetch_ready_n",   ifr_n, 32'd1);
    check_val("fetch_ready_at",  ifr_at, 32'd4);
    check_val("fetch_rdata",     bus.if_rdata, 32'h8C22_0004);
    check_val("fetch_we_cycles", we_n, 32'd0);

    // simultaneous requests: DM first, IF after one idle cycle
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0044;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h0000_0100;
    monitor(12, 1'b0);
    check_val("simul_n_grants", grants.size(), 32'd2);
    check_val("simul_first",    (grants.size() > 0) ? grants[0] : 32'hFFFF_FFFF, 32'h0000_0100);
    check_val("simul_second",   (grants.size() > 1) ? grants[1] : 32'hFFFF_FFFF, 32'h0000_0044);
    check_val("simul_dm_at",    dmr_at, 32'd4);
    check_val("simul_if_at",    ifr_at, 32'd8);
    check_val("simul_dm_rdata", bus.dm_rdata, 32'h0000_0100 ^ 32'hA5A5_5A5A);
    check_val("simul_if_rdata", bus.if_rdata, 32'h0000_0044 ^ 32'hA5A5_5A5A);

    // store leaves dm_rdata alone
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h0000_0200; bus.dm_wdata = 32'hDEAD_BEEF;
    monitor(8, 1'b0);
    bus.dm_we = 1'b0;
    check_val("store_we_cycles", we_n, 32'd3);
    check_val("store_wdata",     first_wdata, 32'hDEAD_BEEF);
    check_val("store_ready_n",   dmr_n, 32'd1);
    check_val("store_ready_at",  dmr_at, 32'd4);
    check_val("store_dm_rdata",  bus.dm_rdata, 32'h0000_0100 ^ 32'hA5A5_5A5A);
    check_val("store_no_if",     ifr_n, 32'd0);

    // starvation: both held high
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h0000_0300;
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0080;
    monitor(28, 1'b1);
    bus.dm_req = 1'b0; bus.if_req = 1'b0;
    check_val("starve_n_grants", grants.size(), 32'd7);
    for (int k = 0; k < 7; k++) begin
      got = (k < grants.size()) ? grants[k] : 32'hFFFF_FFFF;
      check_val($sformatf("starve_grant%0d", k), got, (k == 4) ? 32'h0000_0080 : 32'h0000_0300);
    end
    check_val("starve_if_ready_n", ifr_n, 32'd1);
    monitor(6, 1'b0);
    check_val("starve_drain_idle", grants.size(), 32'd0);

    // reset in the second cycle of an access
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0060;
    @(negedge clk);
    check_val("rstmid_en_before", {31'd0, bus.mem_en}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    bus.if_req = 1'b0;
    #1;
    check_val("rstmid_en_async", {31'd0, bus.mem_en}, 32'd0);
    check_val("rstmid_busy",     {31'd0, bus.busy},   32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    monitor(6, 1'b0);
    check_val("rstmid_no_ready", ifr_n + dmr_n, 32'd0);
    check_val("rstmid_no_grant", grants.size(), 32'd0);
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0040;
    monitor(8, 1'b0);
    check_val("rstmid_after_at", ifr_at, 32'd4);

    // request withdrawn mid-access
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0048;
    @(negedge clk);
    @(negedge clk);
    bus.if_req = 1'b0;
    monitor(8, 1'b0);
    check_val("withdraw_ready_n", ifr_n, 32'd1);
    check_val("withdraw_ready_at", ifr_at, 32'd2);
    check_val("withdraw_no_grant", grants.size(), 32'd0);
    check_val("withdraw_rdata",   bus.if_rdata, 32'h0000_0048 ^ 32'hA5A5_5A5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
